// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side stream reader.
package fifo_rd_pkg;

  localparam int unsigned BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry ordered buffer: push at the tail, pop from the head, entry 0 is always the head.
module stream_skid2
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [DSIZE-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       cnt_o,
  output logic [1:0]       cnt_next_o,
  output logic [DSIZE-1:0] head_o
);

  localparam logic [1:0] DEPTH_C = 2'(BUF_DEPTH);

  logic [DSIZE-1:0] mem_q [BUF_DEPTH];
  logic [DSIZE-1:0] mem_d [BUF_DEPTH];
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic [1:0]       slot;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    mem_d   = mem_q;
    pop_ok  = pop_i && (cnt_q != 2'd0);
    push_ok = push_i && (cnt_q < DEPTH_C);
    // Tail slot is computed after the pop so a simultaneous push/pop keeps ordering.
    slot    = cnt_q - {1'b0, pop_ok};
    if (pop_ok) begin
      mem_d[0] = mem_q[1];
    end
    if (push_ok) begin
      mem_d[slot[0]] = push_data_i;
    end
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;
  assign head_o     = mem_q[0];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a first-word-fall-through FIFO into a registered valid/ready stream; rinc never sees m_ready.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             en,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] words_out,
  output logic             idle
);

  localparam logic [1:0] DEPTH_C = 2'(BUF_DEPTH);

  logic [1:0]       cnt;
  logic [1:0]       cnt_next;
  logic             pop;
  rd_state_e        state_q;
  rd_state_e        state_d;
  logic             idle_q;
  logic [CNT_W-1:0] words_q;
  logic [CNT_W-1:0] words_d;

  // Reset gating keeps the pop strobe low while the buffer is being cleared.
  assign rinc    = rrst_n & en & ~rempty & (cnt < DEPTH_C);
  assign m_valid = (cnt != 2'd0);
  assign pop     = m_valid & m_ready;

  stream_skid2 #(
    .DSIZE(DSIZE)
  ) u_buf (
    .clk        (rclk),
    .rst_n      (rrst_n),
    .push_i     (rinc),
    .push_data_i(rdata),
    .pop_i      (pop),
    .cnt_o      (cnt),
    .cnt_next_o (cnt_next),
    .head_o     (m_data)
  );

  always_comb begin
    state_d = state_q;
    words_d = words_q + {{(CNT_W-1){1'b0}}, pop};
    unique case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) state_d = (cnt_next != 2'd0) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (en) begin
          state_d = RUN;
        end else if (cnt_next == 2'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= IDLE;
      idle_q  <= 1'b1;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= (state_d == IDLE);
      words_q <= words_d;
    end
  end

  assign words_out = words_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: queue-based FIFO and stream model, table-driven backpressure, directed corners, random traffic.
module tb_fifo_stream_reader;

  localparam int DSIZE = 8;
  localparam int CNT_W = 4;

  logic             rclk = 1'b0;
  logic             rrst_n;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic             en;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;
  logic [CNT_W-1:0] words_out;
  logic             idle;

  fifo_stream_reader #(
    .DSIZE(DSIZE),
    .CNT_W(CNT_W)
  ) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rdata    (rdata),
    .rempty   (rempty),
    .rinc     (rinc),
    .en       (en),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .words_out(words_out),
    .idle     (idle)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  logic [DSIZE-1:0] fifo_q [$];
  logic [DSIZE-1:0] mbuf [$];
  int               model_words = 0;
  logic             model_idle = 1'b1;

  logic             s_rinc;
  logic             s_mv;
  logic [DSIZE-1:0] s_md;
  logic [CNT_W-1:0] s_words;
  logic             s_idle;

  typedef struct {
    logic             en;
    logic             rdy;
    logic             rinc;
    logic             mv;
    logic [DSIZE-1:0] md;
    logic [CNT_W-1:0] words;
    logic             idle;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at edge+1, sample/check at edge+3, advance model after the next edge.
  task automatic cycle(input logic en_v, input logic rdy_v);
    logic exp_fetch;
    logic exp_pop;
    logic [DSIZE-1:0] w;
    en      = en_v;
    m_ready = rdy_v;
    rempty  = (fifo_q.size() == 0);
    rdata   = rempty ? '0 : fifo_q[0];
    #2;
    s_rinc  = rinc;
    s_mv    = m_valid;
    s_md    = m_data;
    s_words = words_out;
    s_idle  = idle;
    exp_fetch = en_v && !rempty && (mbuf.size() < 2);
    exp_pop   = (mbuf.size() != 0) && rdy_v;
    chk("rinc", rinc, exp_fetch);
    chk("m_valid", m_valid, mbuf.size() != 0);
    if (mbuf.size() != 0) chk("m_data", m_data, mbuf[0]);
    chk("words_out", words_out, model_words);
    chk("idle", idle, model_idle);
    @(posedge rclk);
    #1;
    if (exp_pop) begin
      w = mbuf.pop_front();
      model_words = (model_words + 1) % (1 << CNT_W);
      $display("word %02h accepted, count %0d", w, model_words);
    end
    if (exp_fetch) mbuf.push_back(fifo_q.pop_front());
    model_idle = !en_v && (mbuf.size() == 0);
  endtask

  initial begin
    int pulses;

    // Backpressure from empty buffer with 11..55 queued: two fetches, hold 11, then stream out.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 4'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 4'd0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 4'd0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 4'd0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 4'd1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 4'd2, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 4'd3, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 4'd4, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd5, 1'b0};

    // Reset with a fetch-eligible environment: rinc must stay low.
    rrst_n  = 1'b0;
    en      = 1'b1;
    m_ready = 1'b0;
    rempty  = 1'b0;
    rdata   = 8'h5A;
    #12;
    chk("rst_rinc", rinc, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_words", words_out, 4'd0);
    chk("rst_idle", idle, 1'b1);
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    en     = 1'b0;

    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].en, tbl[i].rdy);
      if (i < 4 && s_rinc) pulses++;
      chk($sformatf("tbl%0d_rinc", i), s_rinc, tbl[i].rinc);
      chk($sformatf("tbl%0d_mv", i), s_mv, tbl[i].mv);
      if (tbl[i].mv) chk($sformatf("tbl%0d_md", i), s_md, tbl[i].md);
      chk($sformatf("tbl%0d_words", i), s_words, tbl[i].words);
      chk($sformatf("tbl%0d_idle", i), s_idle, tbl[i].idle);
    end
    chk("bp_rinc_pulses", pulses, 2);

    // Streaming: full throughput once the first word is buffered.
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
    chk("stream_words", words_out, 4'd10);

    // Enable drop with a full buffer: DRAIN, deliver both, then IDLE.
    fifo_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("drop_rinc", s_rinc, 1'b0);
    chk("drain_not_idle", idle, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("drain_idle", s_idle, 1'b1);
    chk("drain_words", words_out, 4'd12);

    // Empty FIFO for 10 cycles.
    fifo_q.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1);
      chk("empty_rinc", s_rinc, 1'b0);
    end
    chk("empty_m_valid", m_valid, 1'b0);

    // Asynchronous reset mid-stream with two words buffered.
    fifo_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("mrst_m_valid", m_valid, 1'b0);
    chk("mrst_words", words_out, 4'd0);
    chk("mrst_idle", idle, 1'b1);
    chk("mrst_rinc", rinc, 1'b0);
    mbuf.delete();
    model_words = 0;
    model_idle  = 1'b1;
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;

    // Counter wrap: two leftover words plus 15 new ones give 17 pops.
    for (int i = 0; i < 15; i++) fifo_q.push_back(8'(8'hC0 + i));
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);
    chk("wrap_words", words_out, 4'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) fifo_q.push_back(8'($urandom));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
